mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs the load/store handshake on the data-memory bus and generates byte enables and store-data replication.
- Aligns and sign/zero-extends load data, then registers the MEM/WB result.
- Stalls upstream stages while a memory transaction is outstanding; flags misaligned and timed-out accesses.

Parameters:
- TIMEOUT, 255: max cycles in BUSY awaiting dm_ack_i before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset (asynchronous, active-high)
- mem_re_wr_i  input  2  00 none, 01 load, 10 store, 11 treated as none
- mem_whb_i  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes = W
- alu_res_i  input  32  effective address / ALU result
- reg_val2_i  input  32  store data (rs2)
- pc_add4_i  input  32  PC+4 for link writeback
- alu_res_pc4_i  input  1  1 = writeback pc_add4_i instead of alu_res_i (non-load)
- reg_write_i  input  1  destination write enable
- rd_addr_i  input  5  destination register
- stall_o  output  1  hold EX/MEM and earlier stages (combinational)
- dm_req_o  output  1  memory request (registered)
- dm_we_o  output  1  1 = write
- dm_addr_o  output  32  word-aligned address ({alu_res[31:2],2'b00})
- dm_be_o  output  4  byte enables
- dm_wdata_o  output  32  lane-replicated store data
- dm_ack_i  input  1  transaction complete; rdata valid same cycle for loads
- dm_rdata_i  input  32  read word
- wb_data_o  output  32  registered writeback data
- wb_rd_o  output  5  registered destination
- wb_reg_write_o  output  1  registered write enable
- misalign_o  output  1  one-cycle pulse: misaligned access dropped
- timeout_o  output  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset:
  - State IDLE, counter 0.
  - All registered outputs 0 (dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o, wb_*, misalign_o, timeout_o).
  - Async reset mid-BUSY drops dm_req_o immediately; the transaction is abandoned.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]≠00.
- Store lanes (off = addr[1:0]):
  - B: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - H: be = off[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - W: be = 1111, wdata = rs2.
- Load alignment:
  - Shift dm_rdata_i right by 8*off.
  - B/H: sign-extend. BU/HU: zero-extend. W: unchanged.
  - Loads drive be per size as for stores.
- FSM states: IDLE and BUSY.
- IDLE, no mem op:
  - Next edge: wb_data_o = alu_res_pc4_i ? pc_add4_i : alu_res_i; wb_rd_o = rd_addr_i; wb_reg_write_o = reg_write_i.
  - Latency 1, stall_o = 0.
- IDLE, mem op, misaligned:
  - No request issued.
  - Next edge: wb_reg_write_o = 0, misalign_o = 1 for one cycle.
  - stall_o = 0.
- IDLE, mem op, aligned:
  - stall_o = 1.
  - Next edge: latch dm_addr/be/wdata/we, dm_req_o = 1, counter cleared, wb_reg_write_o = 0 (bubble), go BUSY.
- BUSY:
  - Request fields held stable while dm_req_o = 1.
  - stall_o = !dm_ack_i && !(TIMEOUT≠0 && counter==TIMEOUT).
  - Counter increments each BUSY cycle without ack.
- BUSY with dm_ack_i = 1:
  - Next edge: dm_req_o = 0, go IDLE, wb_rd_o = rd_addr_i, wb_reg_write_o = reg_write_i && load.
  - wb_data_o = extended load data for loads; unchanged for stores.
- BUSY, counter==TIMEOUT (TIMEOUT≠0), no ack:
  - Next edge: dm_req_o = 0, wb_reg_write_o = 0, timeout_o pulse, go IDLE.
- Ack and timeout in the same cycle: ack wins.
- stall_o deasserts in the completion cycle, so upstream advances on the same edge the FSM returns to IDLE. Each instruction is consumed exactly once.
- dm_ack_i in IDLE is ignored.
- Back-to-back mem ops: the next op's request is issued the cycle after return to IDLE. Minimum 2 cycles per access with a zero-wait ack.

Test Plan:
- ALU op alu_res_i=0x1234, rd=5, reg_write=1 → next cycle wb_data_o=0x1234, wb_rd_o=5, wb_reg_write_o=1, stall_o=0, no dm_req_o.
- SB addr=0x103, rs2=0xAABBCCDD → dm_req_o=1, dm_addr_o=0x100, dm_be_o=1000, dm_wdata_o=0xDDDDDDDD, dm_we_o=1. Ack after 3 wait cycles → stall_o high 4 cycles, wb_reg_write_o=0.
- LB addr=0x202, rdata=0x0080FF00 → wb_data_o=0xFFFFFF80. LBU same → 0x00000080. LH addr=0x202, rdata=0x80000000 → 0xFFFF8000.
- LW addr=0x301 → no dm_req_o, misalign_o pulse, wb_reg_write_o=0, stall_o=0.
- TIMEOUT=4, ack never asserted → dm_req_o drops after 5 BUSY cycles, timeout_o pulse, FSM IDLE. Assert rst mid-BUSY → dm_req_o=0 immediately, all outputs 0.
- JAL-style op with alu_res_pc4_i=1, pc_add4_i=0x44 → wb_data_o=0x44. Two back-to-back LW with zero-wait ack → each completes with correct data, no duplicate writeback.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_unit_if;
   logic        dm_req_o;
   logic        dm_we_o;
   logic [31:0] dm_addr_o;
   logic [3:0]  dm_be_o;
   logic [31:0] dm_wdata_o;
   logic        dm_ack_i;
   logic [31:0] dm_rdata_i;

   modport master (output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
                   input  dm_ack_i, dm_rdata_i);
   modport slave  (input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
                   output dm_ack_i, dm_rdata_i);
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: drives the load/store handshake, aligns/extends load data and
// registers the MEM/WB result; stalls upstream while an access is in flight.
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                mem_re_wr_i,
   input  logic [2:0]                mem_whb_i,
   input  logic [31:0]               alu_res_i,
   input  logic [31:0]               reg_val2_i,
   input  logic [31:0]               pc_add4_i,
   input  logic                      alu_res_pc4_i,
   input  logic                      reg_write_i,
   input  logic [4:0]                rd_addr_i,
   output logic                      stall_o,
   mem_access_unit_if.master         dm,
   output logic [31:0]               wb_data_o,
   output logic [4:0]                wb_rd_o,
   output logic                      wb_reg_write_o,
   output logic                      misalign_o,
   output logic                      timeout_o
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;
   state_t r_state, w_next;

   logic          r_req, r_we, r_wb_rw, r_misal, r_to;
   logic [31:0]   r_addr, r_wdata, r_wb_data;
   logic [3:0]    r_be;
   logic [4:0]    r_wb_rd;
   logic [CW-1:0] r_cnt;

   logic        w_load, w_store, w_memop, w_sz_b, w_sz_h, w_uns, w_misaligned;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_sh, w_ld;
   logic        w_issue, w_misal, w_ack, w_abort, w_to_hit;

   assign w_load  = (mem_re_wr_i == 2'b01);
   assign w_store = (mem_re_wr_i == 2'b10);
   assign w_memop = w_load | w_store;
   assign w_off   = alu_res_i[1:0];
   // unlisted size codes fall through to word
   assign w_sz_b  = (mem_whb_i == 3'b000) || (mem_whb_i == 3'b100);
   assign w_sz_h  = (mem_whb_i == 3'b001) || (mem_whb_i == 3'b101);
   assign w_uns   = mem_whb_i[2];

   assign w_misaligned = w_sz_h ? w_off[0] : (!w_sz_b && (w_off != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = reg_val2_i;
      if (w_sz_b) begin
         w_be    = 4'b0001 << w_off;
         w_wdata = {4{reg_val2_i[7:0]}};
      end else if (w_sz_h) begin
         w_be    = w_off[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{reg_val2_i[15:0]}};
      end
   end

   assign w_sh = dm.dm_rdata_i >> {w_off, 3'b000};

   always_comb begin
      w_ld = w_sh;
      if (w_sz_b)      w_ld = {{24{w_sh[7]  & ~w_uns}}, w_sh[7:0]};
      else if (w_sz_h) w_ld = {{16{w_sh[15] & ~w_uns}}, w_sh[15:0]};
   end

   assign w_to_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_misal = 1'b0;
      w_ack   = 1'b0;
      w_abort = 1'b0;
      stall_o = 1'b0;
      case (r_state)
         IDLE: if (w_memop) begin
            if (w_misaligned) w_misal = 1'b1;
            else begin
               w_issue = 1'b1;
               stall_o = 1'b1;
               w_next  = BUSY;
            end
         end
         BUSY: begin
            // ack has priority over an expiring timeout
            if (dm.dm_ack_i) begin
               w_ack  = 1'b1;
               w_next = IDLE;
            end else if (w_to_hit) begin
               w_abort = 1'b1;
               w_next  = IDLE;
            end else stall_o = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_be <= '0; r_wdata <= '0;
         r_wb_data <= '0; r_wb_rd <= '0; r_wb_rw <= 1'b0;
         r_misal <= 1'b0; r_to <= 1'b0; r_cnt <= '0;
      end else begin
         r_misal <= w_misal;
         r_to    <= w_abort;
         if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= w_store;
            r_addr  <= {alu_res_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_wb_rw <= 1'b0;
         end else if (r_state == BUSY) begin
            if (w_ack || w_abort) r_req <= 1'b0;
            if (w_ack) begin
               r_wb_rd <= rd_addr_i;
               r_wb_rw <= reg_write_i & w_load;
               if (w_load) r_wb_data <= w_ld;
            end else begin
               r_wb_rw <= 1'b0;
               r_cnt   <= r_cnt + 1'b1;
            end
         end else if (w_misal) begin
            r_wb_rw <= 1'b0;
         end else begin
            r_wb_data <= alu_res_pc4_i ? pc_add4_i : alu_res_i;
            r_wb_rd   <= rd_addr_i;
            r_wb_rw   <= reg_write_i;
         end
      end
   end

   assign dm.dm_req_o     = r_req;
   assign dm.dm_we_o      = r_we;
   assign dm.dm_addr_o    = r_addr;
   assign dm.dm_be_o      = r_be;
   assign dm.dm_wdata_o   = r_wdata;
   assign wb_data_o       = r_wb_data;
   assign wb_rd_o         = r_wb_rd;
   assign wb_reg_write_o  = r_wb_rw;
   assign misalign_o      = r_misal;
   assign timeout_o       = r_to;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations (TIMEOUT=4).
module tb_mem_access_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  mem_re_wr_i = '0;
   logic [2:0]  mem_whb_i = '0;
   logic [31:0] alu_res_i = '0, reg_val2_i = '0, pc_add4_i = '0;
   logic        alu_res_pc4_i = 1'b0, reg_write_i = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic        stall_o, wb_reg_write_o, misalign_o, timeout_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   int          checks = 0, errors = 0;

   mem_access_unit_if dmif ();

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_re_wr_i(mem_re_wr_i), .mem_whb_i(mem_whb_i),
      .alu_res_i(alu_res_i), .reg_val2_i(reg_val2_i), .pc_add4_i(pc_add4_i),
      .alu_res_pc4_i(alu_res_pc4_i), .reg_write_i(reg_write_i), .rd_addr_i(rd_addr_i),
      .stall_o(stall_o), .dm(dmif.master), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
      .wb_reg_write_o(wb_reg_write_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_op(input logic [1:0] rw, input logic [2:0] whb, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic we);
      mem_re_wr_i = rw; mem_whb_i = whb; alu_res_i = a; reg_val2_i = d;
      rd_addr_i = rd; reg_write_i = we; alu_res_pc4_i = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},   32'(dmif.dm_req_o), 0);
      chk({tag, "_we"},    32'(dmif.dm_we_o), 0);
      chk({tag, "_addr"},  dmif.dm_addr_o, 0);
      chk({tag, "_be"},    32'(dmif.dm_be_o), 0);
      chk({tag, "_wdata"}, dmif.dm_wdata_o, 0);
      chk({tag, "_wbd"},   wb_data_o, 0);
      chk({tag, "_wbrd"},  32'(wb_rd_o), 0);
      chk({tag, "_wbrw"},  32'(wb_reg_write_o), 0);
      chk({tag, "_mis"},   32'(misalign_o), 0);
      chk({tag, "_to"},    32'(timeout_o), 0);
   endtask

   // zero-wait load; leaves the bench just after the completion edge
   task automatic do_load(input string tag, input logic [2:0] whb, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_d);
      set_op(2'b01, whb, a, 32'h0, rd, 1'b1);
      #1 chk({tag, "_stall_issue"}, 32'(stall_o), 1);
      tick();
      chk({tag, "_req"},  32'(dmif.dm_req_o), 1);
      chk({tag, "_we"},   32'(dmif.dm_we_o), 0);
      chk({tag, "_addr"}, dmif.dm_addr_o, {a[31:2], 2'b00});
      chk({tag, "_be"},   32'(dmif.dm_be_o), 32'(exp_be));
      chk({tag, "_bub"},  32'(wb_reg_write_o), 0);
      dmif.dm_ack_i = 1'b1; dmif.dm_rdata_i = rdata;
      #1 chk({tag, "_stall_ack"}, 32'(stall_o), 0);
      tick();
      dmif.dm_ack_i = 1'b0;
      chk({tag, "_data"}, wb_data_o, exp_d);
      chk({tag, "_rd"},   32'(wb_rd_o), 32'(rd));
      chk({tag, "_wbrw"}, 32'(wb_reg_write_o), 1);
      chk({tag, "_reqlo"}, 32'(dmif.dm_req_o), 0);
   endtask

   initial begin
      int st, n;
      dmif.dm_ack_i = 1'b0; dmif.dm_rdata_i = '0;
      #12 chk_zero("reset");
      rst = 1'b0;

      // plain ALU result
      set_op(2'b00, 3'b010, 32'h1234, 32'h0, 5'd5, 1'b1);
      #1 chk("alu_stall", 32'(stall_o), 0);
      tick();
      chk("alu_wbd", wb_data_o, 32'h1234);
      chk("alu_wbrd", 32'(wb_rd_o), 5);
      chk("alu_wbrw", 32'(wb_reg_write_o), 1);
      chk("alu_req", 32'(dmif.dm_req_o), 0);

      // SB with three wait cycles
      set_op(2'b10, 3'b000, 32'h103, 32'hAABBCCDD, 5'd0, 1'b0);
      st = 0;
      for (int i = 0; i < 4; i++) begin
         #1 if (stall_o) st++;
         tick();
         if (i == 0) begin
            chk("sb_req", 32'(dmif.dm_req_o), 1);
            chk("sb_addr", dmif.dm_addr_o, 32'h100);
            chk("sb_be", 32'(dmif.dm_be_o), 32'b1000);
            chk("sb_wdata", dmif.dm_wdata_o, 32'hDDDDDDDD);
            chk("sb_we", 32'(dmif.dm_we_o), 1);
         end
      end
      chk("sb_stall_cycles", st, 4);
      chk("sb_hold_addr", dmif.dm_addr_o, 32'h100);
      dmif.dm_ack_i = 1'b1;
      #1 chk("sb_stall_ack", 32'(stall_o), 0);
      tick();
      dmif.dm_ack_i = 1'b0;
      chk("sb_req_drop", 32'(dmif.dm_req_o), 0);
      chk("sb_wbrw", 32'(wb_reg_write_o), 0);

      // loads back-to-back with alignment and extension
      do_load("lb",  3'b000, 32'h202, 32'h0080FF00, 5'd7, 4'b0100, 32'hFFFFFF80);
      do_load("lbu", 3'b100, 32'h202, 32'h0080FF00, 5'd8, 4'b0100, 32'h00000080);
      do_load("lh",  3'b001, 32'h202, 32'h80000000, 5'd9, 4'b1100, 32'hFFFF8000);
      do_load("lw0", 3'b010, 32'h400, 32'h11223344, 5'd10, 4'b1111, 32'h11223344);
      do_load("lw1", 3'b010, 32'h404, 32'hCAFEBABE, 5'd11, 4'b1111, 32'hCAFEBABE);
      set_op(2'b00, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      chk("nodup_wbrw", 32'(wb_reg_write_o), 0);

      // misaligned word load
      set_op(2'b01, 3'b010, 32'h301, 32'h0, 5'd3, 1'b1);
      #1 chk("mis_stall", 32'(stall_o), 0);
      tick();
      chk("mis_req", 32'(dmif.dm_req_o), 0);
      chk("mis_pulse", 32'(misalign_o), 1);
      chk("mis_wbrw", 32'(wb_reg_write_o), 0);
      set_op(2'b00, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      chk("mis_pulse_end", 32'(misalign_o), 0);

      // timeout: no ack ever
      set_op(2'b10, 3'b010, 32'h500, 32'h12345678, 5'd0, 1'b0);
      tick();
      n = 0;
      while (dmif.dm_req_o && n < 20) begin
         n++;
         if (!stall_o) set_op(2'b00, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
         tick();
      end
      chk("to_busy_cycles", n, 5);
      chk("to_pulse", 32'(timeout_o), 1);
      chk("to_wbrw", 32'(wb_reg_write_o), 0);
      tick();
      chk("to_pulse_end", 32'(timeout_o), 0);

      // async reset mid-BUSY
      set_op(2'b01, 3'b010, 32'h600, 32'h0, 5'd4, 1'b1);
      tick();
      chk("rst_pre_req", 32'(dmif.dm_req_o), 1);
      #2 rst = 1'b1;
      #1 chk_zero("rst_mid");
      set_op(2'b00, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
      rst = 1'b0;
      tick();

      // link writeback
      set_op(2'b00, 3'b010, 32'h999, 32'h0, 5'd1, 1'b1);
      alu_res_pc4_i = 1'b1; pc_add4_i = 32'h44;
      tick();
      chk("jal_wbd", wb_data_o, 32'h44);
      chk("jal_wbrd", 32'(wb_rd_o), 1);

      // code 11 behaves as no memory op; stray ack in IDLE ignored
      set_op(2'b11, 3'b010, 32'h77, 32'h0, 5'd2, 1'b1);
      dmif.dm_ack_i = 1'b1;
      #1 chk("none11_stall", 32'(stall_o), 0);
      tick();
      dmif.dm_ack_i = 1'b0;
      chk("none11_wbd", wb_data_o, 32'h77);
      chk("none11_req", 32'(dmif.dm_req_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
